// File: rtl/q_fixed_pkg.sv
// Fixed-point constants shared by the Q-learning update datapath:
// sign-magnitude Q-format, internal width, saturation limits and reward codes.
package q_fixed_pkg;
    localparam int Q_INT_W  = 4;
    localparam int Q_FRAC_W = 9;
    localparam int Q_W      = 1 + Q_INT_W + Q_FRAC_W;
    localparam int TC_W     = Q_W + 1;
    localparam int INT_W    = 18;
    localparam int SAT_MAX  = 8191;
    localparam int SAT_MIN  = -8191;

    localparam logic [Q_W-1:0] R_POS6 = 14'h0C00;
    localparam logic [Q_W-1:0] R_POS2 = 14'h0400;
    localparam logic [Q_W-1:0] R_NEG2 = 14'h2400;
endpackage

// File: rtl/sm_fixed_conv.sv
// Sign-magnitude <-> two's-complement converter. ENCODE=0 decodes a Q-format
// word; ENCODE=1 saturates a wide two's-complement value and encodes it.
module sm_fixed_conv
    import q_fixed_pkg::*;
#(
    parameter bit ENCODE = 1'b0,
    parameter int IN_W   = Q_W,
    parameter int OUT_W  = TC_W
) (
    input  logic [IN_W-1:0]  val,
    output logic [OUT_W-1:0] res
);
    generate
        if (ENCODE) begin : g_enc
            localparam logic signed [IN_W-1:0] SAT_HI  = IN_W'(SAT_MAX);
            localparam logic signed [IN_W-1:0] SAT_LO  = IN_W'(SAT_MIN);
            localparam logic [Q_W-2:0]         MAG_MAX = (Q_W-1)'(SAT_MAX);
            logic signed [IN_W-1:0] sval_s;
            logic [Q_W-2:0]         mag_s;
            logic                   sign_s;

            // Clamp to the representable range; zero always encodes with a clear sign bit
            always_comb begin
                sval_s = $signed(val);
                sign_s = 1'b0;
                mag_s  = '0;
                if (sval_s > SAT_HI) begin
                    sign_s = 1'b0;
                    mag_s  = MAG_MAX;
                end else if (sval_s < SAT_LO) begin
                    sign_s = 1'b1;
                    mag_s  = MAG_MAX;
                end else if (sval_s[IN_W-1]) begin
                    sign_s = 1'b1;
                    mag_s  = (Q_W-1)'(-sval_s);
                end else begin
                    sign_s = 1'b0;
                    mag_s  = (Q_W-1)'(sval_s);
                end
                res = OUT_W'({sign_s, mag_s});
            end
        end else begin : g_dec
            logic [OUT_W-1:0] mag_s;

            // Negative zero naturally decodes to zero since -0 == 0
            always_comb begin
                mag_s = OUT_W'(val[Q_W-2:0]);
                if (val[Q_W-1]) begin
                    res = -mag_s;
                end else begin
                    res = mag_s;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/q_update.sv
// Three-stage Q-learning update: Q_new = Q_old + alpha*(R + gamma*Qmax - Q_old),
// with valid/ready flow control and a global stall when the output is blocked.
module q_update
    import q_fixed_pkg::*;
#(
    parameter int ALPHA_SH = 2,
    parameter int GAMMA_SH = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_reward,
    input  logic [Q_W-1:0] in_q_old,
    input  logic [Q_W-1:0] in_q_next_max,
    input  logic [4:0]     in_idx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_q_new,
    output logic [4:0]     out_idx
);
    logic stall_s;

    logic signed [TC_W-1:0]  r_tc_s, qo_tc_s, qm_tc_s;
    logic signed [INT_W-1:0] td_s, sum_s;
    logic [Q_W-1:0]          enc_s;

    logic                    v1_r, v2_r, v3_r;
    logic signed [TC_W-1:0]  r1_r, qo1_r, qm1_r, qo2_r;
    logic signed [INT_W-1:0] td2_r;
    logic [4:0]              idx1_r, idx2_r, idx3_r;
    logic [Q_W-1:0]          q3_r;

    assign stall_s   = v3_r & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = v3_r;
    assign out_q_new = q3_r;
    assign out_idx   = idx3_r;

    sm_fixed_conv #(.ENCODE(1'b0), .IN_W(Q_W), .OUT_W(TC_W)) u_dec_r  (.val(in_reward),     .res(r_tc_s));
    sm_fixed_conv #(.ENCODE(1'b0), .IN_W(Q_W), .OUT_W(TC_W)) u_dec_qo (.val(in_q_old),      .res(qo_tc_s));
    sm_fixed_conv #(.ENCODE(1'b0), .IN_W(Q_W), .OUT_W(TC_W)) u_dec_qm (.val(in_q_next_max), .res(qm_tc_s));

    // 18 bits hold |R| + |Qmax| + |Q_old| < 3*8192 without overflow
    assign td_s  = INT_W'(r1_r) + INT_W'(qm1_r >>> GAMMA_SH) - INT_W'(qo1_r);
    assign sum_s = INT_W'(qo2_r) + (td2_r >>> ALPHA_SH);

    sm_fixed_conv #(.ENCODE(1'b1), .IN_W(INT_W), .OUT_W(Q_W)) u_enc (.val(sum_s), .res(enc_s));

    // Pipeline registers; everything freezes while the output is blocked
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v3_r   <= 1'b0;
            r1_r   <= '0;
            qo1_r  <= '0;
            qm1_r  <= '0;
            qo2_r  <= '0;
            td2_r  <= '0;
            idx1_r <= 5'd0;
            idx2_r <= 5'd0;
            idx3_r <= 5'd0;
            q3_r   <= '0;
        end else if (!stall_s) begin
            v1_r <= in_valid;
            v2_r <= v1_r;
            v3_r <= v2_r;
            if (in_valid) begin
                r1_r   <= r_tc_s;
                qo1_r  <= qo_tc_s;
                qm1_r  <= qm_tc_s;
                idx1_r <= in_idx;
            end
            if (v1_r) begin
                td2_r  <= td_s;
                qo2_r  <= qo1_r;
                idx2_r <= idx1_r;
            end
            if (v2_r) begin
                q3_r   <= enc_s;
                idx3_r <= idx2_r;
            end
        end
    end
endmodule
